hex_ascii_parser: RTL

- Inverse of the CRC-to-LCD hex formatter: consumes a stream of ASCII hex characters and assembles a binary word.
- Typical sources: keypad or UART front-end. Typical output: a reference CRC32 value fed to the compare logic.
- Characters arrive over a valid/ready handshake. The assembled word leaves over a second valid/ready handshake.
- Bad characters are flagged and the partial word is discarded.

---
 rtl/hex_ascii_parser.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hex_ascii_parser.sv
// hex_ascii_parser
//   Assembles a binary word from a stream of ASCII hex characters.
//   Digits ('0'-'9', 'A'-'F', 'a'-'f') are shifted in, most significant
//   first. CR/LF ends a partial word early, and the word comes out
//   right-justified. Any other character raises a one-cycle error pulse
//   and discards the partial word.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   char_in      ASCII character
//   char_valid   char_in valid this cycle
//   char_ready   parser accepts a character (low while a word is pending)
//   word_out     assembled word, stable while word_valid is high
//   word_valid   word_out holds a completed word
//   word_ready   consumer accepts word_out
//   digit_count  digits collected for the current word
//   err_invalid  one-cycle pulse after an illegal character is accepted
module hex_ascii_parser #(
    parameter int NUM_DIGITS = 8,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [3:0]        digit_count,
    output logic              err_invalid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(NUM_DIGITS);

    state_t              state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   shift_d;
    logic [WORD_W-1:0]   word_q;
    logic                word_valid_q;
    logic                char_ready_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                err_q;

    logic                is_digit;
    logic                is_term;
    logic [3:0]          nibble;

    // Character classification. Letters map via the low nibble:
    // 'A'/'a' have low nibble 1, so adding 9 yields 10.
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = '0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = char_in[3:0];
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            is_digit = 1'b1;
            nibble   = char_in[3:0] + 4'd9;
        end else if (char_in == 8'h0A || char_in == 8'h0D) begin
            is_term  = 1'b1;
        end
    end

    // Shift form works for any NUM_DIGITS, including a single digit.
    always_comb begin
        shift_d = (shift_q << 4) | WORD_W'(nibble);
        cnt_d   = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            char_ready_q <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE, COLLECT: begin
                    if (char_valid) begin
                        if (is_digit) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            if (cnt_d == LAST_COUNT) begin
                                word_q       <= shift_d;
                                word_valid_q <= 1'b1;
                                char_ready_q <= 1'b0;
                                state_q      <= OUTPUT;
                            end else begin
                                state_q <= COLLECT;
                            end
                        end else if (is_term) begin
                            // A terminator in IDLE has nothing to flush.
                            if (state_q == COLLECT) begin
                                word_q       <= shift_q;
                                word_valid_q <= 1'b1;
                                char_ready_q <= 1'b0;
                                state_q      <= OUTPUT;
                            end
                        end else begin
                            err_q   <= 1'b1;
                            shift_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                OUTPUT: begin
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        char_ready_q <= 1'b1;
                        shift_q      <= '0;
                        cnt_q        <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    word_valid_q <= 1'b0;
                    char_ready_q <= 1'b1;
                    shift_q      <= '0;
                    cnt_q        <= '0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign char_ready  = char_ready_q;
    assign word_out    = word_q;
    assign word_valid  = word_valid_q;
    assign digit_count = cnt_q;
    assign err_invalid = err_q;

endmodule
